// File: rtl/wb_ddr_tester_if.sv
// Pipelined Wishbone bus between the DDR tester (master) and one LiteDRAM user port (slave).
// Word addressed, 32-bit data, sel is always all ones from the master side.
interface wb_ddr_tester_if #(
  parameter int AW = 30
);

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [3:0]    sel;
  logic [31:0]   dat_w;
  logic          stall;
  logic          ack;
  logic          err;
  logic [31:0]   dat_r;

  modport master (
    output cyc,
    output stb,
    output we,
    output adr,
    output sel,
    output dat_w,
    input  stall,
    input  ack,
    input  err,
    input  dat_r
  );

  modport slave (
    input  cyc,
    input  stb,
    input  we,
    input  adr,
    input  sel,
    input  dat_w,
    output stall,
    output ack,
    output err,
    output dat_r
  );

endinterface

// File: rtl/wb_ddr_tester.sv
// Wishbone DDR tester: writes an LFSR pattern over a word range, reads it back and checks it.
// Optional ack watchdog is enabled by defining WB_DDR_TESTER_TIMEOUT_EN.
module wb_ddr_tester #(
  parameter int AW           = 30,
  parameter int MAX_OUTSTAND = 8,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_adr,
  input  logic [AW-1:0]    num_words,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      err_count,
  output logic [AW-1:0]    first_err_adr,
  output logic             bus_err,
  output logic             timeout,
  wb_ddr_tester_if.master  wb
);

  localparam int             OW      = $clog2(MAX_OUTSTAND) + 1;
  localparam logic [OW-1:0]  MAX_OUT = OW'(MAX_OUTSTAND);
  localparam logic [31:0]    TAPS    = 32'h80200003;

  if ((MAX_OUTSTAND < 2) || (MAX_OUTSTAND > 16) ||
      ((MAX_OUTSTAND & (MAX_OUTSTAND - 1)) != 0) || (TIMEOUT_CYC < 2)) begin : g_bad_param
    $error("wb_ddr_tester: illegal MAX_OUTSTAND or TIMEOUT_CYC");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_DRAIN,
    S_RD,
    S_RD_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [AW-1:0] base_r;
  logic [AW-1:0] num_r;
  logic [AW-1:0] issue_cnt;
  logic [AW-1:0] ack_cnt;
  logic [OW-1:0] outstanding;
  logic [31:0]   wr_lfsr;
  logic [31:0]   chk_lfsr;
  logic [31:0]   seed_eff;
  logic          bus_err_r;
  logic          timeout_r;

  logic          start_ok;
  logic          issue_ok;
  logic          accept;
  logic          resp;
  logic          rd_resp;
  logic          mismatch;
  logic          drained;
  logic          wd_fire;
  logic          cyc;
  logic          stb;
  logic          we;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? TAPS : 32'h0);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;

  assign start_ok = start & ((state == S_IDLE) | (state == S_DONE));
  assign issue_ok = (issue_cnt != num_r) & (outstanding < MAX_OUT) & ~bus_err_r;
  assign accept   = stb & ~wb.stall;
  assign resp     = cyc & (wb.ack | wb.err) & (outstanding != '0);
  assign rd_resp  = resp & ((state == S_RD) | (state == S_RD_DRAIN));
  assign mismatch = rd_resp & wb.ack & (wb.dat_r != chk_lfsr);
  assign drained  = (outstanding == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = (num_words == '0) ? S_DONE : S_WR;
        end
      end
      S_WR: begin
        if ((issue_cnt == num_r) || bus_err_r) begin
          state_nxt = S_WR_DRAIN;
        end
      end
      S_WR_DRAIN: begin
        if (drained) begin
          state_nxt = bus_err_r ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        if ((issue_cnt == num_r) || bus_err_r) begin
          state_nxt = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: begin
        if (drained) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (wd_fire) begin
      state_nxt = S_DONE;
    end
  end

  // cyc stays up through each issue phase and falls once its drain completes,
  // which guarantees an idle cycle between the write and read bursts.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    cyc  = 1'b0;
    stb  = 1'b0;
    we   = 1'b0;
    unique case (state)
      S_WR: begin
        busy = 1'b1;
        cyc  = 1'b1;
        stb  = issue_ok;
        we   = 1'b1;
      end
      S_WR_DRAIN: begin
        busy = 1'b1;
        cyc  = ~drained;
        we   = 1'b1;
      end
      S_RD: begin
        busy = 1'b1;
        cyc  = 1'b1;
        stb  = issue_ok;
      end
      S_RD_DRAIN: begin
        busy = 1'b1;
        cyc  = ~drained;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign pass     = done & ~bus_err_r & ~timeout_r & (err_count == 32'h0);
  assign bus_err  = bus_err_r;
  assign timeout  = timeout_r;

  assign wb.cyc   = cyc;
  assign wb.stb   = stb;
  assign wb.we    = we;
  assign wb.adr   = base_r + issue_cnt;
  assign wb.sel   = 4'hF;
  assign wb.dat_w = wr_lfsr;

  // wb_err counts as a response so the drain still terminates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r        <= '0;
      num_r         <= '0;
      issue_cnt     <= '0;
      ack_cnt       <= '0;
      outstanding   <= '0;
      wr_lfsr       <= 32'h0;
      chk_lfsr      <= 32'h0;
      err_count     <= 32'h0;
      first_err_adr <= '0;
      bus_err_r     <= 1'b0;
    end else if (start_ok) begin
      base_r        <= base_adr;
      num_r         <= num_words;
      issue_cnt     <= '0;
      ack_cnt       <= '0;
      outstanding   <= '0;
      wr_lfsr       <= seed_eff;
      chk_lfsr      <= seed_eff;
      err_count     <= 32'h0;
      first_err_adr <= '0;
      bus_err_r     <= 1'b0;
    end else begin
      if (accept) begin
        issue_cnt <= issue_cnt + 1'b1;
        if (we) begin
          wr_lfsr <= lfsr_next(wr_lfsr);
        end
      end

      if (wd_fire) begin
        outstanding <= '0;
      end else if (accept && !resp) begin
        outstanding <= outstanding + 1'b1;
      end else if (!accept && resp) begin
        outstanding <= outstanding - 1'b1;
      end

      if (resp && wb.err) begin
        bus_err_r <= 1'b1;
      end

      if (rd_resp) begin
        ack_cnt  <= ack_cnt + 1'b1;
        chk_lfsr <= lfsr_next(chk_lfsr);
      end

      if (mismatch) begin
        if (err_count != 32'hFFFF_FFFF) begin
          err_count <= err_count + 32'd1;
        end
        if (err_count == 32'h0) begin
          first_err_adr <= base_r + ack_cnt;
        end
      end

      if ((state == S_WR_DRAIN) && drained) begin
        issue_cnt <= '0;
        ack_cnt   <= '0;
      end
    end
  end

`ifdef WB_DDR_TESTER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;

  logic [WW-1:0] wdog;

  assign wd_fire = ~drained & ~resp & (wdog == WW'(TIMEOUT_CYC - 1));

  // Counts consecutive cycles spent waiting on an ack; any response restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog      <= '0;
      timeout_r <= 1'b0;
    end else if (start_ok) begin
      wdog      <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (wd_fire) begin
        timeout_r <= 1'b1;
      end
      if (wd_fire || resp || drained) begin
        wdog <= '0;
      end else begin
        wdog <= wdog + 1'b1;
      end
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign timeout_r = 1'b0;
`endif

endmodule
